// File: rtl/op_rd_pkg.sv
// Shared types and defaults for the URAM bank read sequencer.
package op_rd_pkg;

  localparam int DEF_NUM_BANKS      = 64;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VALID,
    ST_ACK,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/lsb_index_enc.sv
// Lowest-set-bit encoder: index of the least significant set bit plus an any-set flag.
module lsb_index_enc #(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/op_uram_read_ctrl.sv
// Walks the banks of a latched mask lowest-first, doing an enable / valid / ack
// handshake with the clock-domain synchronizer for each bank, with a wait timeout.
//
// state         | meaning
// ST_IDLE       | waiting for start_i
// ST_ISSUE      | one-cycle read enable at rd_bank_o, timer cleared
// ST_WAIT_VALID | waiting for the selected bank's valid to rise
// ST_ACK        | ack held, waiting for the selected bank's valid to fall
// ST_DONE       | one-cycle completion pulse
module op_uram_read_ctrl
  import op_rd_pkg::*;
#(
  parameter int NUM_BANKS      = DEF_NUM_BANKS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [NUM_BANKS-1:0]         bank_mask_i,
  output logic [NUM_BANKS-1:0]         op_uram_enb_o,
  input  logic [NUM_BANKS-1:0]         op_uram_doutb_valid_ps_i,
  output logic                         op_uram_doutb_ack_o,
  output logic                         rd_strobe_o,
  output logic [$clog2(NUM_BANKS)-1:0] rd_bank_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         timeout_err_o
);

  localparam int IDX_W = $clog2(NUM_BANKS);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  rd_state_e            state_q, state_d;
  logic [NUM_BANKS-1:0] mask_q, mask_d;
  logic [NUM_BANKS-1:0] mask_left;
  logic [NUM_BANKS-1:0] enc_in;
  logic [IDX_W-1:0]     bank_q, bank_d;
  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_any;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [TMR_W-1:0]     timer_inc;
  logic                 err_q, err_d;
  logic                 sel_valid;
  logic                 tmo_hit;

  assign mask_left = mask_q & ~(NUM_BANKS'(1) << bank_q);

  // One encoder serves both the initial pick (from the port) and the next pick.
  assign enc_in = (state_q == ST_IDLE) ? bank_mask_i : mask_left;

  lsb_index_enc #(
    .WIDTH (NUM_BANKS),
    .IDX_W (IDX_W)
  ) u_lsb_enc (
    .mask_i (enc_in),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  assign sel_valid = op_uram_doutb_valid_ps_i[bank_q];
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
  assign tmo_hit   = (timer_inc == TMR_LAST);

  always_comb begin
    state_d             = state_q;
    mask_d              = mask_q;
    bank_d              = bank_q;
    timer_d             = timer_q;
    err_d               = err_q;
    op_uram_enb_o       = '0;
    op_uram_doutb_ack_o = 1'b0;
    rd_strobe_o         = 1'b0;
    done_o              = 1'b0;
    busy_o              = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          err_d  = 1'b0;
          mask_d = bank_mask_i;
          if (enc_any) begin
            bank_d  = enc_idx;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        op_uram_enb_o[bank_q] = 1'b1;
        timer_d               = '0;
        state_d               = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        timer_d = timer_inc;
        if (sel_valid) begin
          rd_strobe_o = 1'b1;
          state_d     = ST_ACK;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          mask_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        op_uram_doutb_ack_o = 1'b1;
        timer_d             = timer_inc;
        // A valid fall seen on the timeout cycle still counts as progress.
        if (!sel_valid) begin
          mask_d = mask_left;
          if (enc_any) begin
            bank_d  = enc_idx;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          mask_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      bank_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      bank_q  <= bank_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign rd_bank_o     = bank_q;
  assign timeout_err_o = err_q;

endmodule

// File: doc/op_uram_read_ctrl.md
OP_URAM_READ_CTRL -- requirements
Module: op_uram_read_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 64, meaning the number of output URAM banks and the width of each bank vector.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles spent in any wait state before an error.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: S_AXI_ACLK  in  1  sole clock, all logic on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have port start_i  in  1  single-cycle request to read the banks in bank_mask_i.
REQ-006 SHALL have port bank_mask_i  in  NUM_BANKS  banks to read, sampled only when start_i is accepted.
REQ-007 SHALL have port op_uram_enb_o  in/out: out  NUM_BANKS  one-hot read enable toward the synchronizer.
REQ-008 SHALL have port op_uram_doutb_valid_ps_i  in  NUM_BANKS  per-bank read-data-valid, already synchronised to S_AXI_ACLK.
REQ-009 SHALL have port op_uram_doutb_ack_o  out  1  level acknowledge toward the synchronizer.
REQ-010 SHALL have port rd_strobe_o  out  1  one-cycle pulse telling the AXI read path to capture bank data.
REQ-011 SHALL have port rd_bank_o  out  $clog2(NUM_BANKS)  index of the bank currently being read.
REQ-012 SHALL have ports busy_o, done_o and timeout_err_o  out  1 each: busy; one-cycle completion pulse; sticky timeout flag.

Function
REQ-013 SHALL implement the FSM states IDLE, ISSUE, WAIT_VALID, ACK, DONE.
REQ-014 SHALL, in IDLE with start_i=1 and a non-zero mask, latch the mask, clear timeout_err_o, set rd_bank_o to the lowest set bit, and move to ISSUE.
REQ-015 SHALL, in IDLE with start_i=1 and a zero mask, clear timeout_err_o and go to DONE without asserting any enable.
REQ-016 SHALL ignore start_i in every state other than IDLE.
REQ-017 SHALL, in ISSUE, drive op_uram_enb_o one-hot at rd_bank_o for exactly one cycle, clear the wait timer, then enter WAIT_VALID.
REQ-018 SHALL, in WAIT_VALID, go to ACK when op_uram_doutb_valid_ps_i[rd_bank_o]=1, pulsing rd_strobe_o in that same cycle.
REQ-019 SHALL ignore valid bits of all banks other than rd_bank_o.
REQ-020 SHALL hold op_uram_doutb_ack_o=1 for the whole time the FSM is in ACK, and 0 in every other state.
REQ-021 SHALL, in ACK, wait until op_uram_doutb_valid_ps_i[rd_bank_o]=0, then clear that bit of the latched mask.
REQ-022 SHALL then move to ISSUE with the next-lowest remaining bank if any bits remain, otherwise to DONE.
REQ-023 SHALL, in DONE, pulse done_o for one cycle and return to IDLE.
REQ-024 SHALL assert busy_o in every state except IDLE.
REQ-025 SHALL increment the wait timer each cycle in WAIT_VALID and ACK, saturating the width at $clog2(TIMEOUT_CYCLES+1).
REQ-026 SHALL, when the timer reaches TIMEOUT_CYCLES-1 while waiting, set timeout_err_o, clear the latched mask, and return to IDLE without asserting done_o.
REQ-027 SHALL keep timeout_err_o set until the next accepted start_i.
REQ-028 SHALL give valid falling and timeout in the same cycle precedence to valid falling (normal progress).
REQ-029 SHALL never assert more than one bit of op_uram_enb_o at a time.

Reset
REQ-030 SHALL, on reset, take the state to IDLE, clear the latched mask and the timer, and drive op_uram_enb_o=0, op_uram_doutb_ack_o=0, rd_strobe_o=0, rd_bank_o=0, busy_o=0, done_o=0 and timeout_err_o=0.
REQ-031 SHALL abandon any read in progress when reset asserts mid-operation, with ack dropping asynchronously and no done_o pulse.

Structure
REQ-032 SHALL place the state enum, the NUM_BANKS default and the TIMEOUT_CYCLES default in the shared package op_rd_pkg.
REQ-033 SHALL implement lowest-set-bit selection in the combinational sub-module lsb_index_enc (mask in, index and any-set out).

Verification
REQ-034 SHALL cover: mask=0x5, with a model raising valid 4 cycles after enb and dropping it 3 cycles after ack -> enb pulses at bank 0 then bank 2, two rd_strobe_o pulses with rd_bank_o=0 then 2, one done_o.
REQ-035 SHALL cover: start_i with mask=0 -> done_o 1 cycle after IDLE, no enb, busy_o high for exactly 1 cycle.
REQ-036 SHALL cover: mask=0x8000_0000_0000_0000 with valid never raised, TIMEOUT_CYCLES=16 -> timeout_err_o set 16 cycles after enb, no done_o, then IDLE.
REQ-037 SHALL cover: start_i pulsed during ACK, and valid of a non-selected bank raised -> no state change; the original sequence completes unchanged.
REQ-038 SHALL cover: reset asserted in WAIT_VALID on bank 3 -> all outputs 0 immediately; a new start with mask=0x2 completes normally.
REQ-039 SHALL cover: valid held high with a late drop at exactly timer=TIMEOUT_CYCLES-1 -> normal progress, timeout_err_o stays 0.
